// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg
// Shared definitions for the instruction fetch sequencer:
//   - fetch_state_t : controller state encoding
//   - OPC_HALT      : opcode that stops fetching
//   - *_DEFAULT     : default address/data/opcode/counter widths
//   - opcode_of()   : extracts the opcode field from an instruction word
// Optional feature macro used by the design: FETCH_SINGLE_STEP_EN
package fetch_seq_pkg;

  localparam int AB_DEFAULT  = 11;
  localparam int DB_DEFAULT  = 16;
  localparam int OPW_DEFAULT = 5;
  localparam int CW_DEFAULT  = 16;

  localparam logic [OPW_DEFAULT-1:0] OPC_HALT = 5'b00000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    HALTED = 3'd3,
    PAUSE  = 3'd4
  } fetch_state_t;

  // Opcode lives in the top OPW bits of the instruction word.
  function automatic logic [OPW_DEFAULT-1:0] opcode_of(input logic [DB_DEFAULT-1:0] word);
    return word[DB_DEFAULT-1 -: OPW_DEFAULT];
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg
// Program counter register with clear, increment and hold.
// Ports:
//   clk   in  system clock, rising edge
//   reset in  asynchronous active-high reset (pc -> 0)
//   clear in  synchronous clear to 0 (has priority over incr)
//   incr  in  increment by one; wraps from all-ones to 0
//   pc    out current program counter
module fetch_pc_reg #(
  parameter int AB = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          incr,
  output logic [AB-1:0] pc
);

  localparam logic [AB-1:0] PC_ONE = {{(AB-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (clear) begin
      pc <= '0;
    end else if (incr) begin
      pc <= pc + PC_ONE;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction fetch controller for the 16-bit accumulator CPU. Walks the
// program memory from PC 0, issues each word to decode over valid/ready and
// stops on a HALT opcode; start resumes at the word after the HALT.
// Ports:
//   clk         in  system clock, rising edge
//   reset       in  asynchronous active-high reset
//   start       in  pulse: begin at PC 0 from IDLE, or resume from HALTED
//   step        in  (FETCH_SINGLE_STEP_EN only) release PAUSE to fetch next
//   pc_addr     out program memory address (PC register)
//   mem_data    in  program memory read data, combinational from pc_addr
//   instr       out registered instruction to decode
//   instr_valid out instr valid, held until accepted
//   instr_ready in  decode accepts instr when valid && ready
//   running     out high in FETCH or ISSUE
//   halted      out high in HALTED
//   instr_count out accepted instructions since start from IDLE (saturating)
// Optional feature: define FETCH_SINGLE_STEP_EN to add the step input and a
// PAUSE state entered after every accepted instruction.
//
// state  | meaning
// IDLE   | waiting for start, PC parked at 0
// FETCH  | sample mem_data at PC; HALT -> HALTED, else latch and issue
// ISSUE  | instr_valid high, waiting for instr_ready
// HALTED | HALT word seen, PC points at it; start resumes at PC+1
// PAUSE  | single-step only: waiting for step before the next fetch
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int AB  = AB_DEFAULT,
  parameter int DB  = DB_DEFAULT,
  parameter int OPW = OPW_DEFAULT,
  parameter int CW  = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
`ifdef FETCH_SINGLE_STEP_EN
  input  logic          step,
`endif
  output logic [AB-1:0] pc_addr,
  input  logic [DB-1:0] mem_data,
  output logic [DB-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          running,
  output logic          halted,
  output logic [CW-1:0] instr_count
);

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  fetch_state_t   state, next_state;
  logic           pc_clear, pc_incr;
  logic           load_instr, accept, count_clear;
  logic [OPW-1:0] opcode;

  assign opcode = opcode_of(mem_data);

  fetch_pc_reg #(.AB(AB)) u_pc (
    .clk   (clk),
    .reset (reset),
    .clear (pc_clear),
    .incr  (pc_incr),
    .pc    (pc_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      instr       <= '0;
      instr_valid <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= next_state;
      instr_valid <= (next_state == ISSUE);
      if (load_instr) begin
        instr <= mem_data;
      end
      if (count_clear) begin
        instr_count <= '0;
      end else if (accept && (instr_count != '1)) begin
        instr_count <= instr_count + CNT_ONE;
      end
    end
  end

  always_comb begin
    next_state  = state;
    pc_clear    = 1'b0;
    pc_incr     = 1'b0;
    load_instr  = 1'b0;
    accept      = 1'b0;
    count_clear = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pc_clear    = 1'b1;
          count_clear = 1'b1;
          next_state  = FETCH;
        end
      end
      FETCH: begin
        // The HALT word is neither latched nor counted; PC stays on it.
        if (opcode == OPC_HALT) begin
          next_state = HALTED;
        end else begin
          load_instr = 1'b1;
          pc_incr    = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          accept = 1'b1;
`ifdef FETCH_SINGLE_STEP_EN
          next_state = PAUSE;
`else
          next_state = FETCH;
`endif
        end
      end
      HALTED: begin
        if (start) begin
          pc_incr    = 1'b1;
          next_state = FETCH;
        end
      end
`ifdef FETCH_SINGLE_STEP_EN
      PAUSE: begin
        if (step) begin
          next_state = FETCH;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  assign running = (state == FETCH) || (state == ISSUE);
  assign halted  = (state == HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Directed bench for fetch_sequencer: one instance at the default widths and
// a second at AB=4 for the PC wrap case. Memories are bench-owned arrays read
// combinationally at pc_addr.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: AB=11
  logic        start_a = 1'b0;
  logic        ready_a = 1'b0;
  logic [10:0] pc_a;
  logic [15:0] mem_data_a, instr_a;
  logic        valid_a, running_a, halted_a;
  logic [15:0] count_a;
  logic [15:0] mem_a [0:2047];
  assign mem_data_a = mem_a[pc_a];

  // Instance B: AB=4
  logic        start_b = 1'b0;
  logic        ready_b = 1'b1;
  logic [3:0]  pc_b;
  logic [15:0] mem_data_b, instr_b;
  logic        valid_b, running_b, halted_b;
  logic [15:0] count_b;
  logic [15:0] mem_b [0:15];
  assign mem_data_b = mem_b[pc_b];

`ifdef FETCH_SINGLE_STEP_EN
  logic step = 1'b1;
`endif

  fetch_sequencer dut_a (
    .clk         (clk),
    .reset       (reset),
    .start       (start_a),
`ifdef FETCH_SINGLE_STEP_EN
    .step        (step),
`endif
    .pc_addr     (pc_a),
    .mem_data    (mem_data_a),
    .instr       (instr_a),
    .instr_valid (valid_a),
    .instr_ready (ready_a),
    .running     (running_a),
    .halted      (halted_a),
    .instr_count (count_a)
  );

  fetch_sequencer #(.AB(4)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .start       (start_b),
`ifdef FETCH_SINGLE_STEP_EN
    .step        (step),
`endif
    .pc_addr     (pc_b),
    .mem_data    (mem_data_b),
    .instr       (instr_b),
    .instr_valid (valid_b),
    .instr_ready (ready_b),
    .running     (running_b),
    .halted      (halted_b),
    .instr_count (count_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] iss_q [$];
  int          valid_cycles;
  logic [15:0] pc_at_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Run instance A until halted (bounded), logging accepted instructions.
  task automatic run_a(input int budget);
    iss_q.delete();
    valid_cycles = 0;
    for (int i = 0; i < budget; i++) begin
      tick;
      if (halted_a) break;
      if (valid_a) begin
        valid_cycles++;
        pc_at_valid = {5'd0, pc_a};
        if (ready_a) iss_q.push_back(instr_a);
      end
    end
    chk("a_halt_reached", halted_a, 1);
  endtask

  task automatic run_b(input int budget);
    iss_q.delete();
    valid_cycles = 0;
    for (int i = 0; i < budget; i++) begin
      tick;
      if (halted_b) break;
      if (valid_b) begin
        valid_cycles++;
        pc_at_valid = {12'd0, pc_b};
        if (ready_b) iss_q.push_back(instr_b);
      end
    end
    chk("b_halt_reached", halted_b, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem_a[i] = 16'h0000;
    mem_a[0] = 16'h0801;
    mem_a[1] = 16'h1002;
    mem_a[2] = 16'h0000;
    mem_a[3] = 16'h1802;
    mem_a[4] = 16'h0000;
    for (int i = 0; i < 16; i++) mem_b[i] = 16'h0801;
    mem_b[14] = 16'h0000;

    // Reset state
    #12;
    chk("rst_pc", pc_a, 0);
    chk("rst_instr", instr_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_running", running_a, 0);
    chk("rst_halted", halted_a, 0);
    chk("rst_count", count_a, 0);
    tick;
    reset = 1'b0;
    tick;
    chk("idle_hold_running", running_a, 0);

    // Basic run
    ready_a = 1'b1;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    chk("basic_running", running_a, 1);
    run_a(50);
    chk("basic_n_issued", iss_q.size(), 2);
    chk("basic_i0", iss_q.size() > 0 ? iss_q[0] : 16'hxxxx, 16'h0801);
    chk("basic_i1", iss_q.size() > 1 ? iss_q[1] : 16'hxxxx, 16'h1002);
    chk("basic_valid_cycles", valid_cycles, 2);
    chk("basic_pc", pc_a, 2);
    chk("basic_count", count_a, 2);
    chk("basic_running_off", running_a, 0);

    // Resume from HALTED
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    chk("resume_pc", pc_a, 3);
    run_a(50);
    chk("resume_n_issued", iss_q.size(), 1);
    chk("resume_i0", iss_q.size() > 0 ? iss_q[0] : 16'hxxxx, 16'h1802);
    chk("resume_pc_halt", pc_a, 4);
    chk("resume_count", count_a, 3);

    // Immediate halt
    reset = 1'b1;
    tick;
    reset = 1'b0;
    mem_a[0] = 16'h0000;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    chk("imm_halted_early", halted_a, 0);
    chk("imm_valid0", valid_a, 0);
    tick;
    chk("imm_halted", halted_a, 1);
    chk("imm_pc", pc_a, 0);
    chk("imm_count", count_a, 0);
    chk("imm_valid1", valid_a, 0);
    mem_a[0] = 16'h0801;

    // Backpressure, start ignored in ISSUE, reset in ISSUE
    reset = 1'b1;
    tick;
    reset = 1'b0;
    ready_a = 1'b0;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    tick;
    chk("bp_valid", valid_a, 1);
    chk("bp_instr", instr_a, 16'h0801);
    chk("bp_pc", pc_a, 1);
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    chk("bp_start_ign_pc", pc_a, 1);
    chk("bp_start_ign_valid", valid_a, 1);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("bp_hold_instr", instr_a, 16'h0801);
      chk("bp_hold_valid", valid_a, 1);
      chk("bp_hold_pc", pc_a, 1);
      chk("bp_hold_count", count_a, 0);
    end
    ready_a = 1'b1;
    tick;
    ready_a = 1'b0;
    chk("bp_accept_count", count_a, 1);
    chk("bp_accept_valid", valid_a, 0);
    tick;
    chk("bp_next_valid", valid_a, 1);
    chk("bp_next_instr", instr_a, 16'h1002);
    chk("bp_next_pc", pc_a, 2);
    reset = 1'b1;
    #1;
    chk("rst_issue_valid", valid_a, 0);
    chk("rst_issue_pc", pc_a, 0);
    chk("rst_issue_count", count_a, 0);
    tick;
    reset = 1'b0;
    tick;
    chk("rst_idle_running", running_a, 0);
    chk("rst_idle_halted", halted_a, 0);
    chk("rst_idle_valid", valid_a, 0);

    // Wrap-around on AB=4 instance
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    run_b(100);
    chk("wrap_pre_pc", pc_b, 14);
    chk("wrap_pre_count", count_b, 14);
    mem_b[0] = 16'h0000;
    start_b = 1'b1;
    tick;
    start_b = 1'b0;
    chk("wrap_resume_pc", pc_b, 15);
    run_b(20);
    chk("wrap_n_issued", iss_q.size(), 1);
    chk("wrap_i0", iss_q.size() > 0 ? iss_q[0] : 16'hxxxx, 16'h0801);
    chk("wrap_pc_in_issue", pc_at_valid, 0);
    chk("wrap_halt_pc", pc_b, 0);
    chk("wrap_count", count_b, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch controller for the 16-bit accumulator CPU.
- Drives the program memory address (PC) and samples its combinational read data.
- Issues each instruction to decode over a valid/ready handshake.
- Detects HALT (opcode 5'b00000), stops fetching, and supports start and resume.

Parameters:
- AB, 11, program memory address width (PC width).
- DB, 16, instruction width.
- OPW, 5, opcode field width; opcode = instr[DB-1:DB-OPW].
- CW, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: begin at PC 0 from IDLE, or resume after HALT.
- pc_addr  out  AB  program memory address; equals the PC register.
- mem_data  in  DB  program memory read data, combinational from pc_addr in the same cycle.
- instr  out  DB  registered instruction presented to decode.
- instr_valid  out  1  instr is valid and held stable until accepted.
- instr_ready  in  1  decode accepts instr when valid && ready at a clk edge.
- running  out  1  high in FETCH or ISSUE.
- halted  out  1  high in HALTED.
- instr_count  out  CW  number of accepted instructions since the last start from IDLE; saturates at all-ones.

Behaviour:
- Reset is asynchronous. On assertion: state=IDLE, PC=0, instr=0, instr_valid=0, running=0, halted=0, instr_count=0.
- States: IDLE, FETCH, ISSUE, HALTED, plus PAUSE when the optional feature is compiled in.
- IDLE:
  - start=1 -> PC=0, instr_count=0, go to FETCH.
  - Otherwise hold.
- FETCH (one cycle), sampling mem_data at the edge:
  - If mem_data opcode == OPC_HALT -> go to HALTED. PC is unchanged and points at the HALT word. The HALT word is not issued or counted.
  - Otherwise: instr <= mem_data, PC <= PC+1 (wraps 2^AB-1 -> 0 silently), go to ISSUE.
- ISSUE:
  - instr_valid=1. instr and PC are held while instr_ready=0.
  - On valid && ready: instr_count increments (saturating), go to FETCH. instr_valid drops the next cycle.
  - Peak throughput: one instruction per 2 cycles.
- HALTED:
  - start=1 -> PC <= PC+1, go to FETCH. Execution resumes at the word after the HALT.
  - Otherwise hold. instr_count is retained.
- start is ignored in FETCH and ISSUE.
- Outputs running and halted are decoded from registered state; no combinational path from inputs.
- instr_valid is a registered output: it sets on the FETCH->ISSUE edge and clears on the accepting edge.
- If a HALT word sits at address 2^AB-1, resume wraps the PC to 0.
- Reset mid-operation, including during ISSUE with valid high, aborts immediately and returns to the reset values.

Optional Feature:
- Macro FETCH_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - After each accepted instruction the FSM goes ISSUE -> PAUSE instead of FETCH.
  - PAUSE waits for step=1, then goes to FETCH.
  - running=0 in PAUSE; start is ignored in PAUSE.
- Undefined: no step port, no PAUSE state; ISSUE goes directly to FETCH.

Decomposition:
- Package fetch_seq_pkg contains:
  - state enum typedef (IDLE, FETCH, ISSUE, HALTED, PAUSE);
  - OPC_HALT = 5'b00000;
  - default widths AB/DB/OPW/CW;
  - helper function for opcode extraction.
- One sub-module, fetch_pc_reg: AB-bit PC with clear, load-increment and hold controls; wraps; asynchronous active-high reset.

Test Plan:
- Basic run: program {0:0x0801, 1:0x1002, 2:0x0000}, start pulse, ready tied 1.
  - Expect instr 0x0801 then 0x1002, each with instr_valid high for 1 cycle.
  - Expect halted=1 with pc_addr=2 and instr_count=2.
- Immediate halt: program {0:0x0000}, start -> halted=1 two cycles after start, pc_addr=0, instr_valid never high, instr_count=0.
- Backpressure: instr_ready=0 for 5 cycles during ISSUE -> instr stays 0x0801 and valid stays high; pc_addr stays 1; count increments only on the ready cycle.
- Resume: from HALTED at pc_addr=2 with Mem[3]=0x1802, Mem[4]=0x0000, pulse start -> instr 0x1802 issued, then halted at pc_addr=4, instr_count=3.
- Start ignored and reset: start pulse during ISSUE -> no PC change. Assert reset in ISSUE -> same cycle instr_valid=0 and pc_addr=0; IDLE after release.
- Wrap-around (AB=4): Mem[15]=0x0801, Mem[0]=0x0000, start resume from halt at 14 -> 0x0801 issued, PC wraps to 0, halted at pc_addr=0.
